// File: rtl/counter_checker.sv
// counter_checker: passive monitor that predicts an up-counter's next value and flags mismatches.
// Ports:
//   clk, rst                          checker clock and synchronous active-high reset
//   mon_rst, mon_enable, mon_count    observed counter reset, enable and value
//   locked                            high while tracking
//   mismatch                          one-cycle pulse after a bad sample
//   fault                             sticky error flag (HALT_ON_ERROR=1 only)
//   expected                          predicted value for the current sample
//   err_count, wrap_count             saturating mismatch and max->0 tallies
//   stalled                           idle-timeout flag
// Optional feature: define COUNTER_CHECKER_STALL_EN to build the idle-timeout logic;
// otherwise stalled is tied 0.
module counter_checker #(
    parameter int WIDTH         = 4,
    parameter int ERR_W         = 8,
    parameter int WRAP_W        = 8,
    parameter int HALT_ON_ERROR = 0,
    parameter int STALL_LIMIT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_rst,
    input  logic              mon_enable,
    input  logic [WIDTH-1:0]  mon_count,
    output logic              locked,
    output logic              mismatch,
    output logic              fault,
    output logic [WIDTH-1:0]  expected,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              stalled
);
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
    state_t state, state_nx;
    logic p_rst, p_en;
    logic [WIDTH-1:0] p_cnt;
    logic bad, wrap;
    always_comb begin
        expected = p_rst ? '0 : p_en ? p_cnt + WIDTH'(1) : p_cnt;
        bad      = (state == TRACK) && (mon_count != expected);
        wrap     = (state == TRACK) && !p_rst && p_en && (p_cnt == '1) && (mon_count == '0);
        state_nx = (state == IDLE) ? TRACK :
                   (state == TRACK && bad && HALT_ON_ERROR != 0) ? FAULT : state;
        locked   = (state == TRACK);
        fault    = (state == FAULT);
    end
    // Samples are always captured, so after a mismatch the next prediction
    // is built from the value actually observed (resync).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            p_rst      <= 1'b0;
            p_en       <= 1'b0;
            p_cnt      <= '0;
            mismatch   <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nx;
            p_rst      <= mon_rst;
            p_en       <= mon_enable;
            p_cnt      <= mon_count;
            mismatch   <= bad;
            err_count  <= (bad && err_count != '1) ? err_count + ERR_W'(1) : err_count;
            wrap_count <= (wrap && wrap_count != '1) ? wrap_count + WRAP_W'(1) : wrap_count;
        end
    end
`ifdef COUNTER_CHECKER_STALL_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (rst || mon_enable || mon_rst)
            stall_cnt <= '0;
        else if (state == TRACK && stall_cnt != SW'(STALL_LIMIT))
            stall_cnt <= stall_cnt + SW'(1);
    end
    assign stalled = (stall_cnt == SW'(STALL_LIMIT));
`else
    // Always 0; the parameter is referenced so the default build has no unused parameter.
    assign stalled = 1'b0 && (STALL_LIMIT != 0);
`endif
endmodule
